// File: rtl/mult_float_pipelined.sv
// Three-stage pipelined floating-point multiplier (decode/multiply, normalise/round, pack).
// Subnormal inputs flush to zero; all stages advance together under a single global stall.
module mult_float_pipelined #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic                   i_Flush,
    input  logic                   i_Valid,
    output logic                   o_Ready,
    input  logic [EXP_W+MAN_W:0]   i_Factor1,
    input  logic [EXP_W+MAN_W:0]   i_Factor2,
    input  logic                   i_RoundMode,
    output logic                   o_Valid,
    input  logic                   i_Ready,
    output logic [EXP_W+MAN_W:0]   o_Product,
    output logic [3:0]             o_Flags,
    output logic                   o_Exception
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS_E = EW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [EW-1:0] EMAX_E = EW'(2 ** EXP_W - 1);
    localparam logic signed [EW-1:0] ONE_E  = EW'(1);
    localparam logic signed [EW-1:0] ZERO_E = EW'(0);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic advance;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    logic a_zero, b_zero, a_max, b_max, a_nan, b_nan, a_inf, b_inf, sign_ab;

    logic [MAN_W-1:0]     frac_n;
    logic [MAN_W:0]       frac_r;
    logic signed [EW-1:0] exp_n;
    logic                 guard, sticky, round_up;

    logic                 v1_q, v1_d, sign1_q, sign1_d, rmode1_q, rmode1_d;
    logic [PW-1:0]        prod1_q, prod1_d;
    logic signed [EW-1:0] exp1_q, exp1_d;
    logic                 spec1_q, spec1_d, spec_inv1_q, spec_inv1_d;
    logic [W-1:0]         spec_val1_q, spec_val1_d;

    logic                 v2_q, v2_d, sign2_q, sign2_d, inexact2_q, inexact2_d;
    logic [MAN_W-1:0]     frac2_q, frac2_d;
    logic signed [EW-1:0] exp2_q, exp2_d;
    logic                 spec2_q, spec2_d, spec_inv2_q, spec_inv2_d;
    logic [W-1:0]         spec_val2_q, spec_val2_d;

    logic                 v3_q, v3_d, exc3_q, exc3_d;
    logic [W-1:0]         prod3_q, prod3_d;
    logic [3:0]           flags3_q, flags3_d;

    always_comb begin
        advance = ~v3_q | i_Ready;

        a_exp   = i_Factor1[W-2:MAN_W];
        b_exp   = i_Factor2[W-2:MAN_W];
        a_frac  = i_Factor1[MAN_W-1:0];
        b_frac  = i_Factor2[MAN_W-1:0];
        a_zero  = (a_exp == '0);
        b_zero  = (b_exp == '0);
        a_max   = &a_exp;
        b_max   = &b_exp;
        a_nan   = a_max & (|a_frac);
        b_nan   = b_max & (|b_frac);
        a_inf   = a_max & ~(|a_frac);
        b_inf   = b_max & ~(|b_frac);
        sign_ab = i_Factor1[W-1] ^ i_Factor2[W-1];

        // Product MSB set means significand in [2,4): take one bit higher and bump the exponent.
        if (prod1_q[PW-1]) begin
            frac_n = prod1_q[PW-2:MAN_W+1];
            guard  = prod1_q[MAN_W];
            sticky = |prod1_q[MAN_W-1:0];
            exp_n  = exp1_q + ONE_E;
        end else begin
            frac_n = prod1_q[PW-3:MAN_W];
            guard  = prod1_q[MAN_W-1];
            sticky = |prod1_q[MAN_W-2:0];
            exp_n  = exp1_q;
        end
        round_up = rmode1_q & guard & (sticky | frac_n[0]);
        frac_r   = {1'b0, frac_n} + {{MAN_W{1'b0}}, round_up};

        v1_d = v1_q; sign1_d = sign1_q; rmode1_d = rmode1_q; prod1_d = prod1_q; exp1_d = exp1_q;
        spec1_d = spec1_q; spec_inv1_d = spec_inv1_q; spec_val1_d = spec_val1_q;
        v2_d = v2_q; sign2_d = sign2_q; inexact2_d = inexact2_q; frac2_d = frac2_q; exp2_d = exp2_q;
        spec2_d = spec2_q; spec_inv2_d = spec_inv2_q; spec_val2_d = spec_val2_q;
        v3_d = v3_q; prod3_d = prod3_q; flags3_d = flags3_q; exc3_d = exc3_q;

        if (advance) begin
            v1_d        = i_Valid;
            sign1_d     = sign_ab;
            rmode1_d    = i_RoundMode;
            prod1_d     = {1'b1, a_frac} * {1'b1, b_frac};
            exp1_d      = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_E;
            spec_inv1_d = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
            spec1_d     = a_max | b_max | a_zero | b_zero;
            if (spec_inv1_d)
                spec_val1_d = QNAN;
            else if (a_inf | b_inf)
                spec_val1_d = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else
                spec_val1_d = {sign_ab, {(W-1){1'b0}}};

            v2_d        = v1_q;
            sign2_d     = sign1_q;
            inexact2_d  = guard | sticky;
            frac2_d     = frac_r[MAN_W-1:0];
            exp2_d      = exp_n + (frac_r[MAN_W] ? ONE_E : ZERO_E);
            spec2_d     = spec1_q;
            spec_inv2_d = spec_inv1_q;
            spec_val2_d = spec_val1_q;

            v3_d = v2_q;
            if (spec2_q) begin
                prod3_d  = spec_val2_q;
                flags3_d = {spec_inv2_q, 3'b000};
            end else if (exp2_q >= EMAX_E) begin
                prod3_d  = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flags3_d = 4'b0101;
            end else if (exp2_q <= ZERO_E) begin
                prod3_d  = {sign2_q, {(W-1){1'b0}}};
                flags3_d = 4'b0011;
            end else begin
                prod3_d  = {sign2_q, exp2_q[EXP_W-1:0], frac2_q};
                flags3_d = {3'b000, inexact2_q};
            end
            exc3_d = |flags3_d[3:1];
        end

        if (i_Flush) begin
            v1_d = 1'b0;
            v2_d = 1'b0;
            v3_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            v1_q <= '0; sign1_q <= '0; rmode1_q <= '0; prod1_q <= '0; exp1_q <= '0;
            spec1_q <= '0; spec_inv1_q <= '0; spec_val1_q <= '0;
            v2_q <= '0; sign2_q <= '0; inexact2_q <= '0; frac2_q <= '0; exp2_q <= '0;
            spec2_q <= '0; spec_inv2_q <= '0; spec_val2_q <= '0;
            v3_q <= '0; prod3_q <= '0; flags3_q <= '0; exc3_q <= '0;
        end else begin
            v1_q <= v1_d; sign1_q <= sign1_d; rmode1_q <= rmode1_d; prod1_q <= prod1_d; exp1_q <= exp1_d;
            spec1_q <= spec1_d; spec_inv1_q <= spec_inv1_d; spec_val1_q <= spec_val1_d;
            v2_q <= v2_d; sign2_q <= sign2_d; inexact2_q <= inexact2_d; frac2_q <= frac2_d; exp2_q <= exp2_d;
            spec2_q <= spec2_d; spec_inv2_q <= spec_inv2_d; spec_val2_q <= spec_val2_d;
            v3_q <= v3_d; prod3_q <= prod3_d; flags3_q <= flags3_d; exc3_q <= exc3_d;
        end
    end

    assign o_Ready     = advance;
    assign o_Valid     = v3_q;
    assign o_Product   = prod3_q;
    assign o_Flags     = flags3_q;
    assign o_Exception = exc3_q;
endmodule

// File: tb/tb_mult_float_pipelined.sv
// Bench for mult_float_pipelined (half precision): directed vectors, randomized streaming
// against an exact-arithmetic reference model, backpressure, async reset and flush.
module tb_mult_float_pipelined;
    logic        i_Clk, i_Rst_n, i_Flush, i_Valid, o_Ready, i_RoundMode, o_Valid, i_Ready, o_Exception;
    logic [15:0] i_Factor1, i_Factor2, o_Product;
    logic [3:0]  o_Flags;

    int n_checks = 0;
    int n_errors = 0;
    logic [19:0] exp_q [$];

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic [15:0] p;
        logic [3:0]  f;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV] = '{
        '{16'h4000, 16'h4200, 1'b1, 16'h4600, 4'b0000},
        '{16'h3E00, 16'h3E00, 1'b1, 16'h4080, 4'b0000},
        '{16'h3E01, 16'h3E01, 1'b1, 16'h4082, 4'b0001},
        '{16'h3E01, 16'h3E01, 1'b0, 16'h4081, 4'b0001},
        '{16'h7BFF, 16'h7BFF, 1'b1, 16'h7C00, 4'b0101},
        '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'b0101},
        '{16'h0400, 16'h0400, 1'b1, 16'h0000, 4'b0011},
        '{16'h8000, 16'h4000, 1'b1, 16'h8000, 4'b0000},
        '{16'h7C00, 16'h0000, 1'b1, 16'h7E00, 4'b1000},
        '{16'hFC00, 16'h4000, 1'b1, 16'hFC00, 4'b0000},
        '{16'h7E00, 16'h3C00, 1'b1, 16'h7E00, 4'b1000}
    };

    mult_float_pipelined #(.EXP_W(5), .MAN_W(10)) dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Flush(i_Flush), .i_Valid(i_Valid), .o_Ready(o_Ready),
        .i_Factor1(i_Factor1), .i_Factor2(i_Factor2), .i_RoundMode(i_RoundMode), .o_Valid(o_Valid),
        .i_Ready(i_Ready), .o_Product(o_Product), .o_Flags(o_Flags), .o_Exception(o_Exception)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Exact model: integer significand product, normalise by bit length, round on the remainder.
    function automatic logic [19:0] fp_model(input logic [15:0] a, input logic [15:0] b, input logic mode);
        int ea, eb, fa, fb, n, sh, e;
        longint p, t, q, rem, half;
        bit s, an, bn, ai, bi, az, bz, inexact;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        s  = a[15] ^ b[15];
        an = (ea == 31) && (fa != 0); bn = (eb == 31) && (fb != 0);
        ai = (ea == 31) && (fa == 0); bi = (eb == 31) && (fb == 0);
        az = (ea == 0);               bz = (eb == 0);
        if (an || bn || (ai && bz) || (bi && az)) return {4'b1000, 16'h7E00};
        if (ai || bi) return {4'b0000, s, 5'h1F, 10'h000};
        if (az || bz) return {4'b0000, s, 15'h0000};
        p = longint'(1024 + fa) * longint'(1024 + fb);
        n = 0; t = p;
        while (t != 0) begin n++; t = t >> 1; end
        sh   = n - 11;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = longint'(1) << (sh - 1);
        inexact = (rem != 0);
        if (mode && ((rem > half) || ((rem == half) && q[0]))) q = q + 1;
        e = ea + eb - 15 + (n - 21);
        if (q == 2048) begin q = q >> 1; e = e + 1; end
        if (e >= 31) return {4'b0101, s, 5'h1F, 10'h000};
        if (e <= 0)  return {4'b0011, s, 15'h0000};
        return {3'b000, inexact, s, e[4:0], q[9:0]};
    endfunction

    function automatic logic [15:0] rand_operand();
        logic [15:0] r;
        r = 16'($urandom);
        if ($urandom_range(0, 7) != 0) r[14:10] = 5'($urandom_range(6, 24));
        return r;
    endfunction

    task automatic test_reset();
        n_checks++; if (o_Valid !== 1'b0)     begin n_errors++; $display("FAIL reset_valid: got %b expected 0", o_Valid); end
        n_checks++; if (o_Ready !== 1'b1)     begin n_errors++; $display("FAIL reset_ready: got %b expected 1", o_Ready); end
        n_checks++; if (o_Product !== 16'h0)  begin n_errors++; $display("FAIL reset_product: got %h expected 0000", o_Product); end
        n_checks++; if (o_Flags !== 4'h0)     begin n_errors++; $display("FAIL reset_flags: got %b expected 0000", o_Flags); end
        n_checks++; if (o_Exception !== 1'b0) begin n_errors++; $display("FAIL reset_exception: got %b expected 0", o_Exception); end
    endtask

    task automatic test_directed();
        i_Ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            i_Valid = 1'b1; i_Factor1 = vecs[i].a; i_Factor2 = vecs[i].b; i_RoundMode = vecs[i].m;
            @(posedge i_Clk); #1;
            i_Valid = 1'b0;
            @(posedge i_Clk); #1;
            n_checks++;
            if (o_Valid !== 1'b0) begin n_errors++; $display("FAIL latency_early[%0d]: got o_Valid %b expected 0", i, o_Valid); end
            @(posedge i_Clk); #1;
            n_checks++;
            if (o_Valid !== 1'b1 || o_Product !== vecs[i].p || o_Flags !== vecs[i].f || o_Exception !== (|vecs[i].f[3:1])) begin
                n_errors++;
                $display("FAIL directed[%0d] %h x %h m%0d: got v=%b p=%h f=%b x=%b expected v=1 p=%h f=%b x=%b",
                         i, vecs[i].a, vecs[i].b, vecs[i].m, o_Valid, o_Product, o_Flags, o_Exception,
                         vecs[i].p, vecs[i].f, |vecs[i].f[3:1]);
            end
        end
        @(posedge i_Clk); #1;
    endtask

    task automatic test_stream(input int n_ops, input int stall_start, input int stall_len, input bit rand_ready);
        int sent = 0, got = 0, cyc = 0;
        logic [15:0] a = '0, b = '0, held_p = '0;
        logic [3:0]  held_f = '0;
        logic        m = 1'b0, have = 1'b0, holding = 1'b0;
        logic [19:0] e;
        exp_q.delete();
        while (got < n_ops && cyc < n_ops * 20 + 100) begin
            if (!have && sent < n_ops) begin
                a = rand_operand(); b = rand_operand(); m = 1'($urandom_range(0, 1)); have = 1'b1;
            end
            i_Valid = have; i_Factor1 = a; i_Factor2 = b; i_RoundMode = m;
            if (rand_ready) i_Ready = ($urandom_range(0, 3) != 0);
            else            i_Ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            @(negedge i_Clk);
            n_checks++;
            if (o_Ready !== (!o_Valid || i_Ready)) begin
                n_errors++; $display("FAIL ready_rule: got o_Ready %b expected %b", o_Ready, (!o_Valid || i_Ready));
            end
            if (holding) begin
                n_checks++;
                if (o_Valid !== 1'b1 || o_Product !== held_p || o_Flags !== held_f) begin
                    n_errors++;
                    $display("FAIL hold_stable: got v=%b p=%h f=%b expected v=1 p=%h f=%b", o_Valid, o_Product, o_Flags, held_p, held_f);
                end
            end
            holding = o_Valid && !i_Ready; held_p = o_Product; held_f = o_Flags;
            if (o_Valid && i_Ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL stream_extra: got result %h expected none", o_Product);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    if (o_Product !== e[15:0] || o_Flags !== e[19:16] || o_Exception !== (|e[19:17])) begin
                        n_errors++;
                        $display("FAIL stream_result[%0d]: got p=%h f=%b x=%b expected p=%h f=%b x=%b",
                                 got, o_Product, o_Flags, o_Exception, e[15:0], e[19:16], |e[19:17]);
                    end
                end
            end
            if (i_Valid && o_Ready) begin
                exp_q.push_back(fp_model(a, b, m)); have = 1'b0; sent++;
            end
            @(posedge i_Clk); #1;
            cyc++;
        end
        i_Valid = 1'b0; i_Ready = 1'b1;
        n_checks++;
        if (got != n_ops || exp_q.size() != 0) begin
            n_errors++; $display("FAIL stream_count: got %0d results expected %0d", got, n_ops);
        end
    endtask

    task automatic test_reset_midstream();
        i_Ready = 1'b1; i_RoundMode = 1'b1; i_Valid = 1'b1;
        i_Factor1 = 16'h4000; i_Factor2 = 16'h4200; @(posedge i_Clk); #1;
        i_Factor1 = 16'h3E00; i_Factor2 = 16'h3E00; @(posedge i_Clk); #1;
        i_Factor1 = 16'h3E01; i_Factor2 = 16'h3E01; @(posedge i_Clk); #1;
        i_Valid = 1'b0;
        n_checks++;
        if (o_Valid !== 1'b1 || o_Product !== 16'h4600) begin
            n_errors++; $display("FAIL pre_reset_result: got v=%b p=%h expected v=1 p=4600", o_Valid, o_Product);
        end
        #2 i_Rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_Valid !== 1'b0 || o_Ready !== 1'b1 || o_Product !== 16'h0 || o_Flags !== 4'h0 || o_Exception !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got v=%b r=%b p=%h f=%b x=%b expected v=0 r=1 p=0000 f=0000 x=0",
                     o_Valid, o_Ready, o_Product, o_Flags, o_Exception);
        end
        @(posedge i_Clk); #2 i_Rst_n = 1'b1;
        @(posedge i_Clk); #1;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (o_Valid !== 1'b0) begin n_errors++; $display("FAIL stale_after_reset[%0d]: got o_Valid %b expected 0", c, o_Valid); end
            @(posedge i_Clk); #1;
        end
    endtask

    task automatic test_flush();
        i_Ready = 1'b1; i_RoundMode = 1'b1; i_Valid = 1'b1;
        i_Factor1 = 16'h4000; i_Factor2 = 16'h4200; @(posedge i_Clk); #1;
        i_Factor1 = 16'h3E00; i_Factor2 = 16'h3E00; @(posedge i_Clk); #1;
        i_Factor1 = 16'h3E01; i_Factor2 = 16'h3E01; i_Flush = 1'b1; @(posedge i_Clk); #1;
        i_Flush = 1'b0; i_Valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (o_Valid !== 1'b0) begin n_errors++; $display("FAIL flushed_result[%0d]: got o_Valid %b p=%h expected 0", c, o_Valid, o_Product); end
            @(posedge i_Clk); #1;
        end
        i_Valid = 1'b1; i_Factor1 = 16'h3E00; i_Factor2 = 16'h3E00;
        @(posedge i_Clk); #1;
        i_Valid = 1'b0;
        @(posedge i_Clk); #1;
        n_checks++;
        if (o_Valid !== 1'b0) begin n_errors++; $display("FAIL post_flush_early: got o_Valid %b expected 0", o_Valid); end
        @(posedge i_Clk); #1;
        n_checks++;
        if (o_Valid !== 1'b1 || o_Product !== 16'h4080) begin
            n_errors++; $display("FAIL post_flush_result: got v=%b p=%h expected v=1 p=4080", o_Valid, o_Product);
        end
        i_Ready = 1'b0; i_Flush = 1'b1;
        @(posedge i_Clk); #1;
        i_Flush = 1'b0;
        n_checks++;
        if (o_Valid !== 1'b0) begin n_errors++; $display("FAIL flush_under_stall: got o_Valid %b expected 0", o_Valid); end
        i_Ready = 1'b1;
        @(posedge i_Clk); #1;
    endtask

    initial begin
        i_Rst_n = 1'b0; i_Flush = 1'b0; i_Valid = 1'b0; i_Ready = 1'b1; i_RoundMode = 1'b1;
        i_Factor1 = '0; i_Factor2 = '0;
        #3;
        test_reset();
        repeat (2) @(posedge i_Clk);
        #2 i_Rst_n = 1'b1;
        @(posedge i_Clk); #1;
        test_directed();
        test_stream(300, -1, 0, 1'b1);
        test_stream(5, 4, 6, 1'b0);
        test_reset_midstream();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
